// File: rtl/uart_wb_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : uart_wb_ctrl_if
// Brief   : 8-bit Wishbone register port between uart_wb_ctrl and a 16550 core
// Revision: 1.0 - initial release
// ============================================================================
interface uart_wb_ctrl_if;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic [3:0] wb_sel_o;
  logic       wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/uart_wb_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : uart_wb_ctrl
// Brief   : Wishbone master that configures a 16550 UART, then polls LSR and
//           moves bytes between TX/RX streams and THR/RBR.
//           Optional ack timeout: define UART_CTRL_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module uart_wb_ctrl #(
  parameter logic [15:0] DIVISOR        = 16'd27,
  parameter logic [7:0]  LCR_CFG        = 8'h03,
  parameter logic [7:0]  FCR_CFG        = 8'hC7,
  parameter logic [7:0]  IER_CFG        = 8'h00,
  parameter int          POLL_GAP       = 4,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  wire logic       wb_clk_i,
  input  wire logic       wb_rst_i,
  input  wire logic       start,
  output logic            busy,
  output logic            init_done,
  uart_wb_ctrl_if.master  wb,
  input  wire logic [7:0] tx_data,
  input  wire logic       tx_valid,
  output logic            tx_ready,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  input  wire logic       rx_ready,
  output logic [3:0]      lsr_err,
  output logic            wb_err
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_GAP_WAIT = 3'd2,
    ST_RD_LSR   = 3'd3,
    ST_RD_RBR   = 3'd4,
    ST_WR_THR   = 3'd5
  } state_t;

  localparam int             GW         = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0]  c_GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [GW-1:0]  c_GAP_ONE  = GW'(1);
  // With no gap configured the FSM re-polls LSR immediately after any access.
  localparam state_t         c_AFTER    = (POLL_GAP == 0) ? ST_RD_LSR : ST_GAP_WAIT;

  state_t        r_state;
  logic [2:0]    r_step;
  logic [GW-1:0] r_gap;
  logic          r_cyc;
  logic          r_we;
  logic [2:0]    r_adr;
  logic [7:0]    r_dat;
  logic          r_busy;
  logic          r_init_done;
  logic          r_tx_ready;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic [3:0]    r_lsr_err;

  logic [2:0]    w_init_adr;
  logic [7:0]    w_init_dat;
  logic          w_timeout;
  logic          w_ack;
  logic          w_done;

  always_comb begin
    w_init_adr = 3'd0;
    w_init_dat = 8'h00;
    case (r_step)
      3'd0: begin w_init_adr = 3'd3; w_init_dat = LCR_CFG | 8'h80; end
      3'd1: begin w_init_adr = 3'd0; w_init_dat = DIVISOR[7:0];    end
      3'd2: begin w_init_adr = 3'd1; w_init_dat = DIVISOR[15:8];   end
      3'd3: begin w_init_adr = 3'd3; w_init_dat = LCR_CFG & 8'h7F; end
      3'd4: begin w_init_adr = 3'd2; w_init_dat = FCR_CFG;         end
      3'd5: begin w_init_adr = 3'd1; w_init_dat = IER_CFG;         end
      default: ;
    endcase
  end

`ifdef UART_CTRL_TIMEOUT_EN
  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] c_TO_ONE   = TW'(1);

  logic [TW-1:0] r_to_cnt;
  logic          r_wb_err;

  assign w_timeout = r_cyc && !wb.wb_ack_i && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_to_cnt <= '0;
      r_wb_err <= 1'b0;
    end else begin
      if (!r_cyc || wb.wb_ack_i || w_timeout)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + c_TO_ONE;
      if (w_timeout)
        r_wb_err <= 1'b1;
    end
  end

  assign wb_err = r_wb_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
  assign wb_err           = 1'b0;
`endif

  assign w_ack  = r_cyc && wb.wb_ack_i;
  assign w_done = r_cyc && (wb.wb_ack_i || w_timeout);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_step      <= 3'd0;
      r_gap       <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= 3'd0;
      r_dat       <= 8'h00;
      r_busy      <= 1'b0;
      r_init_done <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_lsr_err   <= 4'h0;
    end else begin
      r_tx_ready <= 1'b0;
      // A completing RBR read below overrides this clear on the same edge.
      if (r_rx_valid && rx_ready)
        r_rx_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_INIT;
            r_step  <= 3'd0;
            r_busy  <= 1'b1;
          end
        end

        ST_INIT: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= w_init_adr;
            r_dat <= w_init_dat;
          end else if (w_done) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            if (r_step == 3'd5) begin
              r_init_done <= 1'b1;
              r_state     <= ST_RD_LSR;
            end else begin
              r_step <= r_step + 3'd1;
            end
          end
        end

        ST_GAP_WAIT: begin
          if (r_gap == c_GAP_LAST) begin
            r_gap   <= '0;
            r_state <= ST_RD_LSR;
          end else begin
            r_gap <= r_gap + c_GAP_ONE;
          end
        end

        ST_RD_LSR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= 1'b0;
            r_adr <= 3'd5;
            r_dat <= 8'h00;
          end else if (w_done) begin
            r_cyc   <= 1'b0;
            r_state <= c_AFTER;
            if (w_ack) begin
              r_lsr_err <= r_lsr_err | wb.wb_dat_i[4:1];
              if (wb.wb_dat_i[0] && !r_rx_valid)
                r_state <= ST_RD_RBR;
              else if (wb.wb_dat_i[5] && tx_valid)
                r_state <= ST_WR_THR;
            end
          end
        end

        ST_RD_RBR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= 1'b0;
            r_adr <= 3'd0;
            r_dat <= 8'h00;
          end else if (w_done) begin
            r_cyc   <= 1'b0;
            r_state <= c_AFTER;
            if (w_ack) begin
              r_rx_data  <= wb.wb_dat_i;
              r_rx_valid <= 1'b1;
            end
          end
        end

        ST_WR_THR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= 3'd0;
            r_dat <= tx_data;
          end else if (w_done) begin
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_state    <= c_AFTER;
            r_tx_ready <= w_ack;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb.wb_adr_o = r_adr;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_we_o  = r_we;
  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_cyc;
  assign wb.wb_sel_o = 4'b1111;

  assign busy      = r_busy;
  assign init_done = r_init_done;
  assign tx_ready  = r_tx_ready;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign lsr_err   = r_lsr_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_wb_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_uart_wb_ctrl
// Brief   : Directed bench for uart_wb_ctrl with a zero-wait Wishbone UART model
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_wb_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, init_done, tx_ready, rx_valid, wb_err;
  logic [7:0] rx_data;
  logic [3:0] lsr_err;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       ack_en = 1'b1;
  logic [7:0] lsr_v = 8'h00;
  logic [7:0] rbr_v = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int hi_n     = 0;

  always #5 clk = ~clk;

  uart_wb_ctrl_if bus ();

  assign bus.wb_ack_i = bus.wb_cyc_o & bus.wb_stb_o & ack_en;
  assign bus.wb_dat_i = (bus.wb_adr_o == 3'd5) ? lsr_v : rbr_v;

`ifdef UART_CTRL_TIMEOUT_EN
  uart_wb_ctrl #(.TIMEOUT_CYCLES(8)) dut (
`else
  uart_wb_ctrl dut (
`endif
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start    (start),
    .busy     (busy),
    .init_done(init_done),
    .wb       (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .lsr_err  (lsr_err),
    .wb_err   (wb_err)
  );

  typedef struct {
    logic [2:0] adr;
    logic       we;
    logic [7:0] dat;
    int         cyc;
    int         hi;
  } acc_t;

  acc_t q[$];

  // Logs every acknowledged access with its cycle stamp and cyc-high length.
  always @(posedge clk) begin
    cyc_n++;
    if (rst || !bus.wb_cyc_o) begin
      hi_n = 0;
    end else begin
      hi_n++;
      if (bus.wb_ack_i) begin
        q.push_back('{bus.wb_adr_o, bus.wb_we_o, bus.wb_dat_o, cyc_n, hi_n});
        hi_n = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic next_acc(output acc_t a);
    int n;
    n = 0;
    while (q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      chk("access_wait_timeout", 32'd0, 32'd1);
      a = '{3'd7, 1'b1, 8'hFF, 0, 0};
    end else begin
      a = q.pop_front();
    end
  endtask

  task automatic wait_lsr(output acc_t a);
    for (int k = 0; k < 6; k++) begin
      next_acc(a);
      if (a.adr == 3'd5 && !a.we) return;
    end
    chk("lsr_poll_missing", 32'd0, 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cyc"},       bus.wb_cyc_o, 0);
    chk({tag, "_stb"},       bus.wb_stb_o, 0);
    chk({tag, "_we"},        bus.wb_we_o, 0);
    chk({tag, "_adr"},       bus.wb_adr_o, 0);
    chk({tag, "_dat_o"},     bus.wb_dat_o, 0);
    chk({tag, "_sel"},       bus.wb_sel_o, 4'hF);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_tx_ready"},  tx_ready, 0);
    chk({tag, "_rx_valid"},  rx_valid, 0);
    chk({tag, "_rx_data"},   rx_data, 0);
    chk({tag, "_lsr_err"},   lsr_err, 0);
    chk({tag, "_wb_err"},    wb_err, 0);
  endtask

  typedef struct {
    logic [2:0] adr;
    logic [7:0] dat;
  } init_t;

  typedef struct {
    logic [7:0] lsr;
    logic [7:0] rbr;
    logic       txv;
    logic [7:0] txd;
    logic [2:0] e_adr;
    logic       e_we;
    logic [7:0] e_dat;
    logic       e_rxv;
  } vec_t;

  init_t it[6];
  vec_t  vt[7];

  initial begin
    acc_t a, b;
    int   n;

    it[0] = '{3'd3, 8'h83};
    it[1] = '{3'd0, 8'h1B};
    it[2] = '{3'd1, 8'h00};
    it[3] = '{3'd3, 8'h03};
    it[4] = '{3'd2, 8'hC7};
    it[5] = '{3'd1, 8'h00};

    vt[0] = '{8'h60, 8'h00, 1'b1, 8'hA5, 3'd0, 1'b1, 8'hA5, 1'b0};
    vt[1] = '{8'h00, 8'h00, 1'b1, 8'hA5, 3'd5, 1'b0, 8'h00, 1'b0};
    vt[2] = '{8'h61, 8'h3C, 1'b1, 8'h5A, 3'd0, 1'b0, 8'h00, 1'b1};
    vt[3] = '{8'h20, 8'h00, 1'b0, 8'h11, 3'd5, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'h01, 8'h77, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b1};
    vt[5] = '{8'h21, 8'h99, 1'b1, 8'hC3, 3'd0, 1'b0, 8'h00, 1'b1};
    vt[6] = '{8'h40, 8'h00, 1'b1, 8'h66, 3'd5, 1'b0, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Init sequence
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 6; i++) begin
      next_acc(a);
      chk($sformatf("init%0d_adr", i), a.adr, it[i].adr);
      chk($sformatf("init%0d_we", i), a.we, 1);
      chk($sformatf("init%0d_dat", i), a.dat, it[i].dat);
      chk($sformatf("init%0d_cyc_high", i), a.hi, 1);
      if (i > 0) chk($sformatf("init%0d_spacing", i), a.cyc - b.cyc, 2);
      chk($sformatf("init%0d_init_done", i), init_done, (i == 5) ? 1 : 0);
      b = a;
    end

    // Service-mode vector table
    for (int i = 0; i < 7; i++) begin
      wait_lsr(a);
      lsr_v    = vt[i].lsr;
      rbr_v    = vt[i].rbr;
      tx_valid = vt[i].txv;
      tx_data  = vt[i].txd;
      wait_lsr(a);
      next_acc(b);
      chk($sformatf("vec%0d_adr", i), b.adr, vt[i].e_adr);
      chk($sformatf("vec%0d_we", i), b.we, vt[i].e_we);
      if (vt[i].e_we) chk($sformatf("vec%0d_dat", i), b.dat, vt[i].e_dat);
      chk($sformatf("vec%0d_tx_ready", i), tx_ready, vt[i].e_we);
      chk($sformatf("vec%0d_rx_valid", i), rx_valid, vt[i].e_rxv);
      if (vt[i].e_rxv) chk($sformatf("vec%0d_rx_data", i), rx_data, vt[i].rbr);
      lsr_v    = 8'h00;
      tx_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_tx_ready_pulse", i), tx_ready, 0);
      if (vt[i].e_rxv) begin
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk($sformatf("vec%0d_rx_taken", i), rx_valid, 0);
      end
    end

    // Idle poll period
    wait_lsr(a);
    next_acc(b);
    chk("idle_poll_adr", b.adr, 5);
    chk("idle_poll_period", b.cyc - a.cyc, 6);

    // RX beats TX, THR written only after the following LSR poll
    lsr_v = 8'h61; rbr_v = 8'h3C; tx_valid = 1'b1; tx_data = 8'h5A;
    wait_lsr(a);
    next_acc(b);
    chk("prio_rbr_adr", b.adr, 0);
    chk("prio_rbr_we", b.we, 0);
    chk("prio_rx_data", rx_data, 8'h3C);
    next_acc(b);
    chk("prio_repoll_adr", b.adr, 5);
    next_acc(b);
    chk("prio_thr_adr", b.adr, 0);
    chk("prio_thr_we", b.we, 1);
    chk("prio_thr_dat", b.dat, 8'h5A);
    lsr_v = 8'h00; tx_valid = 1'b0;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;

    // RX backpressure: no RBR read while rx_valid is held
    wait_lsr(a);
    lsr_v = 8'h01; rbr_v = 8'h11;
    wait_lsr(a);
    next_acc(b);
    chk("bp_first_rbr", b.adr, 0);
    rbr_v = 8'h22;
    for (int k = 0; k < 3; k++) begin
      next_acc(b);
      chk($sformatf("bp_hold_poll%0d", k), b.adr, 5);
    end
    chk("bp_rx_data_held", rx_data, 8'h11);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("bp_rx_cleared", rx_valid, 0);
    next_acc(b);
    chk("bp_poll_after_clear", b.adr, 5);
    next_acc(b);
    chk("bp_second_rbr_adr", b.adr, 0);
    chk("bp_second_rbr_we", b.we, 0);
    chk("bp_second_rx_data", rx_data, 8'h22);
    lsr_v = 8'h00;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;

    // Sticky LSR error bits
    chk("lsr_err_clean", lsr_err, 0);
    wait_lsr(a);
    lsr_v = 8'h04;
    wait_lsr(a);
    chk("lsr_err_pe", lsr_err, 4'h2);
    lsr_v = 8'h1E;
    wait_lsr(a);
    chk("lsr_err_all", lsr_err, 4'hF);
    lsr_v = 8'h00;
    wait_lsr(a);
    wait_lsr(a);
    chk("lsr_err_sticky", lsr_err, 4'hF);

    // Reset in the middle of a THR access
    lsr_v = 8'h60; tx_valid = 1'b1; tx_data = 8'hDE;
    wait_lsr(a);
    ack_en = 1'b0;
    @(negedge clk);
    chk("mid_thr_cyc", bus.wb_cyc_o, 1);
    chk("mid_thr_we", bus.wb_we_o, 1);
    chk("mid_thr_dat", bus.wb_dat_o, 8'hDE);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    rst = 1'b0; ack_en = 1'b1; lsr_v = 8'h00; tx_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_cyc", bus.wb_cyc_o, 0);
    q.delete();

`ifdef UART_CTRL_TIMEOUT_EN
    // Ack timeout on init step 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    next_acc(a);
    next_acc(a);
    ack_en = 1'b0;
    @(negedge clk);
    n = 0;
    while (bus.wb_cyc_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("to_cyc_cycles", n, 8);
    chk("to_wb_err", wb_err, 1);
    ack_en = 1'b1;
    next_acc(a);
    chk("to_next_adr", a.adr, 3);
    chk("to_next_dat", a.dat, 8'h03);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
